// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, BYPASS and
// optional IDCODE data registers, and decoded strobes for an external debug DR.
// Optional feature macro: JTAG_IDCODE_EN (adds the IDCODE register, opcode 1, and
// makes IDCODE the reset instruction; otherwise the reset instruction is BYPASS).
module jtag_tap_ctrl #(
    parameter int unsigned         IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0DB3,
    parameter logic [IR_WIDTH-1:0] DBG_INSTR    = 5'h11
) (
    input  logic                tck_i,
    input  logic                rst_i,
    input  logic                tms_i,
    input  logic                td_i,
    output logic                td_o,
    output logic                tdo_oe_o,
    output logic                test_logic_reset_o,
    output logic                run_test_idle_o,
    output logic                capture_dr_o,
    output logic                shift_dr_o,
    output logic                update_dr_o,
    output logic                dbg_sel_o,
    input  logic                dbg_tdo_i,
    output logic [IR_WIDTH-1:0] ir_o
);

    localparam logic [3:0] StTlr   = 4'd0;
    localparam logic [3:0] StRti   = 4'd1;
    localparam logic [3:0] StSelDr = 4'd2;
    localparam logic [3:0] StCapDr = 4'd3;
    localparam logic [3:0] StShDr  = 4'd4;
    localparam logic [3:0] StEx1Dr = 4'd5;
    localparam logic [3:0] StPauDr = 4'd6;
    localparam logic [3:0] StEx2Dr = 4'd7;
    localparam logic [3:0] StUpdDr = 4'd8;
    localparam logic [3:0] StSelIr = 4'd9;
    localparam logic [3:0] StCapIr = 4'd10;
    localparam logic [3:0] StShIr  = 4'd11;
    localparam logic [3:0] StEx1Ir = 4'd12;
    localparam logic [3:0] StPauIr = 4'd13;
    localparam logic [3:0] StEx2Ir = 4'd14;
    localparam logic [3:0] StUpdIr = 4'd15;

    // Capture pattern: ...0001, so the mandatory "01" appears in the low two bits.
    localparam logic [IR_WIDTH-1:0] IrCapture = {{(IR_WIDTH-1){1'b0}}, 1'b1};

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IrIdcode   = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] ResetInstr = IrIdcode;
`else
    localparam logic [IR_WIDTH-1:0] ResetInstr = '1;
`endif

    logic [3:0]          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic                bypass_q, bypass_d;
    logic                td_q, td_d;
    logic                oe_q, oe_d;
    logic                sel_dbg, sel_idcode, sel_bypass;
    logic                idcode_tdo;
    logic                dr_tdo;

    // The debug DR wins if its opcode ever collides with the IDCODE opcode.
    assign sel_dbg    = (ir_q == DBG_INSTR);
    assign sel_bypass = !sel_dbg && !sel_idcode;

    // TAP state transition function
    always_comb begin
        state_d = state_q;
        case (state_q)
            StTlr:   state_d = tms_i ? StTlr   : StRti;
            StRti:   state_d = tms_i ? StSelDr : StRti;
            StSelDr: state_d = tms_i ? StSelIr : StCapDr;
            StCapDr: state_d = tms_i ? StEx1Dr : StShDr;
            StShDr:  state_d = tms_i ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms_i ? StUpdDr : StPauDr;
            StPauDr: state_d = tms_i ? StEx2Dr : StPauDr;
            StEx2Dr: state_d = tms_i ? StUpdDr : StShDr;
            StUpdDr: state_d = tms_i ? StSelDr : StRti;
            StSelIr: state_d = tms_i ? StTlr   : StCapIr;
            StCapIr: state_d = tms_i ? StEx1Ir : StShIr;
            StShIr:  state_d = tms_i ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms_i ? StUpdIr : StPauIr;
            StPauIr: state_d = tms_i ? StEx2Ir : StPauIr;
            StEx2Ir: state_d = tms_i ? StUpdIr : StShIr;
            StUpdIr: state_d = tms_i ? StSelDr : StRti;
            default: state_d = StTlr;
        endcase
    end

    // Instruction register: capture/shift path plus the latched instruction
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        case (state_q)
            StCapIr: ir_shift_d = IrCapture;
            StShIr:  ir_shift_d = {td_i, ir_shift_q[IR_WIDTH-1:1]};
            StUpdIr: ir_d       = ir_shift_q;
            StTlr:   ir_d       = ResetInstr;
            default: ;
        endcase
    end

    // BYPASS register: captures 0, otherwise a single-bit delay from td_i
    always_comb begin
        bypass_d = bypass_q;
        if (sel_bypass && state_q == StCapDr) begin
            bypass_d = 1'b0;
        end else if (sel_bypass && state_q == StShDr) begin
            bypass_d = td_i;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    assign sel_idcode = !sel_dbg && (ir_q == IrIdcode);
    assign idcode_tdo = idcode_q[0];

    // IDCODE register: loads the device ID on capture, shifts out LSB first
    always_comb begin
        idcode_d = idcode_q;
        if (sel_idcode && state_q == StCapDr) begin
            idcode_d = IDCODE_VALUE;
        end else if (sel_idcode && state_q == StShDr) begin
            idcode_d = {td_i, idcode_q[31:1]};
        end
    end

    // IDCODE register state
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            idcode_q <= '0;
        end else begin
            idcode_q <= idcode_d;
        end
    end
`else
    logic unused_idcode;

    assign sel_idcode    = 1'b0;
    assign idcode_tdo    = 1'b0;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    assign dr_tdo = sel_dbg ? dbg_tdo_i : (sel_idcode ? idcode_tdo : bypass_q);

    // Serial output selection; td_o holds its last value outside the shift states
    always_comb begin
        td_d = td_q;
        oe_d = 1'b0;
        if (state_q == StShIr) begin
            td_d = ir_shift_q[0];
            oe_d = 1'b1;
        end else if (state_q == StShDr) begin
            td_d = dr_tdo;
            oe_d = 1'b1;
        end
    end

    // Rising-edge state: FSM, instruction and data registers
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StTlr;
            ir_q       <= ResetInstr;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
        end
    end

    // Falling-edge output stage so TDO is stable at the next rising edge
    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            td_q <= 1'b0;
            oe_q <= 1'b0;
        end else begin
            td_q <= td_d;
            oe_q <= oe_d;
        end
    end

    // Combinational state decodes
    always_comb begin
        test_logic_reset_o = (state_q == StTlr);
        run_test_idle_o    = (state_q == StRti);
        capture_dr_o       = sel_dbg && (state_q == StCapDr);
        shift_dr_o         = sel_dbg && (state_q == StShDr);
        update_dr_o        = sel_dbg && (state_q == StUpdDr);
    end

    assign dbg_sel_o = sel_dbg;
    assign ir_o      = ir_q;
    assign td_o      = td_q;
    assign tdo_oe_o  = oe_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: a queue-based reference model of the TAP
// (transition table, bit queues for IR/DR) is stepped alongside the DUT every TCK.
module tb_jtag_tap_ctrl;

    localparam int unsigned IR_W = 5;
    localparam logic [31:0] IDCODE = 32'h1000_0DB3;
    localparam logic [4:0]  DBG = 5'h11;
`ifdef JTAG_IDCODE_EN
    localparam logic [4:0]  RESET_IR = 5'h01;
`else
    localparam logic [4:0]  RESET_IR = 5'h1F;
`endif

    localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5,
                   PAU_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10,
                   SH_IR = 11, EX1_IR = 12, PAU_IR = 13, EX2_IR = 14, UPD_IR = 15;

    logic            tck_i = 1'b0;
    logic            rst_i, tms_i, td_i, dbg_tdo_i;
    logic            td_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o;
    logic            capture_dr_o, shift_dr_o, update_dr_o, dbg_sel_o;
    logic [IR_W-1:0] ir_o;

    jtag_tap_ctrl dut (
        .tck_i              (tck_i),
        .rst_i              (rst_i),
        .tms_i              (tms_i),
        .td_i               (td_i),
        .td_o               (td_o),
        .tdo_oe_o           (tdo_oe_o),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .update_dr_o        (update_dr_o),
        .dbg_sel_o          (dbg_sel_o),
        .dbg_tdo_i          (dbg_tdo_i),
        .ir_o               (ir_o)
    );

    always #5 tck_i = ~tck_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int        nxt0 [16];
    int        nxt1 [16];
    int        m_state;
    logic [4:0] m_ir;
    bit        m_irq [$];
    bit        m_drq [$];
    logic      m_tdo, m_oe;
    bit        obs [$];
    int        cnt_cap, cnt_sh, cnt_upd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic init_table();
        nxt0[TLR] = RTI;    nxt1[TLR] = TLR;
        nxt0[RTI] = RTI;    nxt1[RTI] = SEL_DR;
        nxt0[SEL_DR] = CAP_DR; nxt1[SEL_DR] = SEL_IR;
        nxt0[SEL_IR] = CAP_IR; nxt1[SEL_IR] = TLR;
        for (int k = 0; k < 2; k++) begin
            // DR column at base 3, IR column at base 10: Cap,Sh,Ex1,Pau,Ex2,Upd
            int b;
            b = (k == 0) ? CAP_DR : CAP_IR;
            nxt0[b]   = b + 1; nxt1[b]   = b + 2;
            nxt0[b+1] = b + 1; nxt1[b+1] = b + 2;
            nxt0[b+2] = b + 3; nxt1[b+2] = b + 5;
            nxt0[b+3] = b + 3; nxt1[b+3] = b + 4;
            nxt0[b+4] = b + 1; nxt1[b+4] = b + 5;
            nxt0[b+5] = RTI;   nxt1[b+5] = SEL_DR;
        end
    endtask

    function automatic bit m_sel_dbg();
        return m_ir == DBG;
    endfunction

    function automatic bit m_sel_idcode();
`ifdef JTAG_IDCODE_EN
        return !m_sel_dbg() && m_ir == 5'h01;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_state = TLR;
        m_ir    = RESET_IR;
        m_irq.delete();
        repeat (IR_W) m_irq.push_back(1'b0);
        m_drq.delete();
        m_drq.push_back(1'b0);
        m_tdo = 1'b0;
        m_oe  = 1'b0;
    endtask

    task automatic model_rise(input logic tms, input logic tdi);
        if (m_state == CAP_IR) begin
            m_irq.delete();
            m_irq.push_back(1'b1);
            repeat (IR_W - 1) m_irq.push_back(1'b0);
        end else if (m_state == SH_IR) begin
            void'(m_irq.pop_front());
            m_irq.push_back(tdi);
        end else if (m_state == UPD_IR) begin
            for (int i = 0; i < IR_W; i++) m_ir[i] = m_irq[i];
        end else if (m_state == TLR) begin
            m_ir = RESET_IR;
        end else if (m_state == CAP_DR && !m_sel_dbg()) begin
            m_drq.delete();
            if (m_sel_idcode()) begin
                for (int i = 0; i < 32; i++) m_drq.push_back(IDCODE[i]);
            end else begin
                m_drq.push_back(1'b0);
            end
        end else if (m_state == SH_DR && !m_sel_dbg()) begin
            void'(m_drq.pop_front());
            m_drq.push_back(tdi);
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic model_fall();
        m_oe = 1'b0;
        if (m_state == SH_IR) begin
            m_tdo = m_irq[0];
            m_oe  = 1'b1;
        end else if (m_state == SH_DR) begin
            m_tdo = m_sel_dbg() ? dbg_tdo_i : m_drq[0];
            m_oe  = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_eq("tlr", test_logic_reset_o, m_state == TLR);
        check_eq("rti", run_test_idle_o, m_state == RTI);
        check_eq("tdo_oe", tdo_oe_o, m_oe);
        check_eq("td_o", td_o, m_tdo);
        check_eq("ir_o", ir_o, m_ir);
        check_eq("dbg_sel", dbg_sel_o, m_sel_dbg());
        check_eq("capture_dr", capture_dr_o, m_state == CAP_DR && m_sel_dbg());
        check_eq("shift_dr", shift_dr_o, m_state == SH_DR && m_sel_dbg());
        check_eq("update_dr", update_dr_o, m_state == UPD_DR && m_sel_dbg());
    endtask

    task automatic tick(input logic tms, input logic tdi);
        tms_i     = tms;
        td_i      = tdi;
        dbg_tdo_i = 1'($urandom_range(0, 1));
        @(posedge tck_i);
        model_rise(tms, tdi);
        @(negedge tck_i);
        model_fall();
        #1;
        compare_all();
        if (tdo_oe_o) obs.push_back(td_o);
        cnt_cap += int'(capture_dr_o);
        cnt_sh  += int'(shift_dr_o);
        cnt_upd += int'(update_dr_o);
    endtask

    function automatic logic [63:0] pack_obs();
        logic [63:0] v = '0;
        for (int i = 0; i < obs.size() && i < 64; i++) v[i] = obs[i];
        return v;
    endfunction

    task automatic clear_obs();
        obs.delete();
        cnt_cap = 0;
        cnt_sh  = 0;
        cnt_upd = 0;
    endtask

    // Starts and ends in Run-Test/Idle
    task automatic ir_scan(input logic [4:0] v);
        clear_obs();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) tick(i == IR_W - 1, v[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Starts and ends in Run-Test/Idle; pauses for 4 cycles after bit pause_at
    task automatic dr_scan(input int n, input logic [63:0] din, input int pause_at);
        clear_obs();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i == pause_at), din[i]);
            if (i == pause_at && i != n - 1) begin
                repeat (4) begin
                    tick(1'b0, 1'($urandom_range(0, 1)));
                    check_eq("oe_paused", tdo_oe_o, 1'b0);
                end
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_tlr_check();
        repeat (5) tick(1'b1, 1'($urandom_range(0, 1)));
        check_eq("five_tms_tlr", test_logic_reset_o, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    logic [63:0] rnd;
    logic [4:0]  op;
    int          n;

    initial begin
        init_table();
        clear_obs();
        rst_i = 1'b1; tms_i = 1'b1; td_i = 1'b0; dbg_tdo_i = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(posedge tck_i); #1;
        compare_all();
        @(negedge tck_i); #1;
        rst_i = 1'b0;

        // First edge after release evaluates tms from TLR
        tick(1'b0, 1'b0);
        check_eq("rti_after_reset", run_test_idle_o, 1'b1);

`ifdef JTAG_IDCODE_EN
        dr_scan(32, 64'h0, 40);
        check_eq("idcode_out", pack_obs(), {32'h0, IDCODE});
`else
        dr_scan(9, 64'hA5, 2);
        check_eq("reset_bypass_out", pack_obs(), 64'h14A);
`endif

        ir_scan(5'h11);
        check_eq("ir_capture_out", pack_obs(), 64'h01);
        check_eq("ir_dbg", ir_o, 5'h11);
        check_eq("dbg_sel_set", dbg_sel_o, 1'b1);

        dr_scan(7, 64'h5B, 3);
        check_eq("dbg_cap_cnt", cnt_cap, 1);
        check_eq("dbg_sh_cnt", cnt_sh, 7);
        check_eq("dbg_upd_cnt", cnt_upd, 1);

        // Abort an IR scan after 3 bits with reset
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_mid_ir", ir_o, RESET_IR);
        @(negedge tck_i); #1;
        compare_all();
        rst_i = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("no_update_after_rst", ir_o, RESET_IR);

        ir_scan(5'h1F);
        dr_scan(9, 64'hA5, 2);
        check_eq("bypass_out", pack_obs(), 64'h14A);

        // Randomized scans and TMS walks
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: op = DBG;
                1: op = 5'h01;
                2: op = 5'h1F;
                default: op = 5'($urandom);
            endcase
            ir_scan(op);
            check_eq("rand_ir", ir_o, op);
            n   = $urandom_range(1, 40);
            rnd = {$urandom, $urandom};
            dr_scan(n, rnd, $urandom_range(0, n));
            repeat (20) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            goto_tlr_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
